// File: rtl/pattern_generator_multi.sv
// Multi-mode animated test-pattern source: legacy border/box, colour bars, checkerboard,
// scrolling ramp, bouncing box and solid white, with mode and animation state latched at frame start.
module pattern_generator_multi #(
  parameter int WIDTH      = 800,
  parameter int HEIGHT     = 600,
  parameter int XW         = 10,
  parameter int BORDER     = 20,
  parameter int BOX        = 20,
  parameter int STEP       = 2,
  parameter int CHECK_LOG2 = 5
) (
  input  logic          pixelClk,
  input  logic          nReset,
  input  logic          vs,
  input  logic          de,
  input  logic [XW-1:0] pixelsX,
  input  logic [XW-1:0] pixelsY,
  input  logic [2:0]    mode,
  output logic [7:0]    r,
  output logic [7:0]    g,
  output logic [7:0]    b,
  output logic [7:0]    frameCount
);

  localparam logic [XW:0] STEP_C   = (XW+1)'(STEP);
  localparam logic [XW:0] BOX_C    = (XW+1)'(BOX);
  localparam logic [XW:0] X_LIM    = (XW+1)'(WIDTH - BOX);
  localparam logic [XW:0] Y_LIM    = (XW+1)'(HEIGHT - BOX);
  localparam logic [XW:0] BORDER_C = (XW+1)'(BORDER);
  localparam logic [XW:0] RIGHT_C  = (XW+1)'(WIDTH - BORDER);
  localparam logic [XW:0] BOTTOM_C = (XW+1)'(HEIGHT - BORDER);
  localparam logic [XW:0] CX_LO    = (XW+1)'((WIDTH/2 >= 10) ? WIDTH/2 - 10 : 0);
  localparam logic [XW:0] CX_HI    = (XW+1)'(WIDTH/2 + 10);
  localparam logic [XW:0] CY_LO    = (XW+1)'((HEIGHT/2 >= 10) ? HEIGHT/2 - 10 : 0);
  localparam logic [XW:0] CY_HI    = (XW+1)'(HEIGHT/2 + 10);
  localparam logic [XW:0] BAR1     = (XW+1)'(1*WIDTH/8);
  localparam logic [XW:0] BAR2     = (XW+1)'(2*WIDTH/8);
  localparam logic [XW:0] BAR3     = (XW+1)'(3*WIDTH/8);
  localparam logic [XW:0] BAR4     = (XW+1)'(4*WIDTH/8);
  localparam logic [XW:0] BAR5     = (XW+1)'(5*WIDTH/8);
  localparam logic [XW:0] BAR6     = (XW+1)'(6*WIDTH/8);
  localparam logic [XW:0] BAR7     = (XW+1)'(7*WIDTH/8);

  logic          last_vs;
  logic          sof;
  logic [2:0]    active_mode;
  logic [XW-1:0] box_x;
  logic [XW-1:0] box_y;
  logic          dir_x;
  logic          dir_y;
  logic [XW+1:0] next_x;
  logic [XW+1:0] next_y;
  logic [XW:0]   xe;
  logic [XW:0]   ye;
  logic [XW:0]   bxe;
  logic [XW:0]   bye;
  logic [7:0]    ramp;
  logic [23:0]   pix;

  assign sof  = ~last_vs & vs;
  assign xe   = {1'b0, pixelsX};
  assign ye   = {1'b0, pixelsY};
  assign bxe  = {1'b0, box_x};
  assign bye  = {1'b0, box_y};
  assign ramp = pixelsX[7:0] + frameCount;

  // Returns {new_dir, new_pos}; one extra bit keeps pos+STEP from wrapping.
  function automatic logic [XW+1:0] step_axis(input logic [XW:0] pos, input logic dir,
                                               input logic [XW:0] lim);
    logic [XW:0] sum;
    sum = pos + STEP_C;
    if (dir) begin
      if (sum >= lim) step_axis = {1'b0, lim};
      else            step_axis = {1'b1, sum};
    end else begin
      if (pos <= STEP_C) step_axis = {1'b1, {(XW+1){1'b0}}};
      else               step_axis = {1'b0, pos - STEP_C};
    end
  endfunction

  assign next_x = step_axis(bxe, dir_x, X_LIM);
  assign next_y = step_axis(bye, dir_y, Y_LIM);

  always_comb begin
    pix = 24'h202020;
    case (active_mode)
      3'd1: begin
        if      (xe < BAR1) pix = 24'hFFFFFF;
        else if (xe < BAR2) pix = 24'hFFFF00;
        else if (xe < BAR3) pix = 24'h00FFFF;
        else if (xe < BAR4) pix = 24'h00FF00;
        else if (xe < BAR5) pix = 24'hFF00FF;
        else if (xe < BAR6) pix = 24'hFF0000;
        else if (xe < BAR7) pix = 24'h0000FF;
        else                pix = 24'h000000;
      end
      3'd2: pix = (pixelsX[CHECK_LOG2] ^ pixelsY[CHECK_LOG2] ^ frameCount[5]) ? 24'hFFFFFF
                                                                              : 24'h000000;
      3'd3: pix = {ramp, ramp, ramp};
      3'd4: begin
        if (xe >= bxe && xe < bxe + BOX_C && ye >= bye && ye < bye + BOX_C)
          pix = 24'hFFFFFF;
      end
      3'd5: pix = 24'hFFFFFF;
      default: begin
        // Priority: centre box, then top/bottom bars, then the side bars.
        if (xe >= CX_LO && xe <= CX_HI && ye >= CY_LO && ye <= CY_HI) pix = 24'hFFFFFF;
        else if (ye < BORDER_C || ye >= BOTTOM_C)                     pix = 24'h0000FF;
        else if (xe < BORDER_C)                                       pix = 24'hFF0000;
        else if (xe >= RIGHT_C)                                       pix = 24'h00FF00;
      end
    endcase
  end

  always_ff @(posedge pixelClk or negedge nReset) begin
    if (!nReset) begin
      last_vs     <= 1'b1;
      active_mode <= 3'd0;
      frameCount  <= 8'd0;
      box_x       <= '0;
      box_y       <= '0;
      dir_x       <= 1'b1;
      dir_y       <= 1'b1;
    end else begin
      last_vs <= vs;
      if (sof) begin
        active_mode <= mode;
        frameCount  <= frameCount + 8'd1;
        box_x       <= next_x[XW-1:0];
        dir_x       <= next_x[XW+1];
        box_y       <= next_y[XW-1:0];
        dir_y       <= next_y[XW+1];
      end
    end
  end

  always_ff @(posedge pixelClk or negedge nReset) begin
    if (!nReset) begin
      {r, g, b} <= 24'h000000;
    end else begin
      {r, g, b} <= de ? pix : 24'h000000;
    end
  end

endmodule

// File: tb/tb_pattern_generator_multi.sv
// Self-checking bench for pattern_generator_multi: directed and randomized stimulus compared
// against a frame-level model (SOF count, latched mode, closed-form box bounce).
module tb_pattern_generator_multi;

  localparam int W      = 800;
  localparam int H      = 600;
  localparam int BORDER = 20;
  localparam int BOX    = 20;
  localparam int STEP   = 2;

  logic       pixelClk = 1'b0;
  logic       nReset   = 1'b0;
  logic       vs       = 1'b1;
  logic       de       = 1'b0;
  logic [9:0] pixelsX  = '0;
  logic [9:0] pixelsY  = '0;
  logic [2:0] mode     = 3'd0;
  logic [7:0] r, g, b, frameCount;

  int checks = 0;
  int errors = 0;

  int   m_sofs;
  int   m_mode;
  logic m_last_vs;

  logic [23:0] bar_colors [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  pattern_generator_multi dut (
    .pixelClk(pixelClk), .nReset(nReset), .vs(vs), .de(de),
    .pixelsX(pixelsX), .pixelsY(pixelsY), .mode(mode),
    .r(r), .g(g), .b(b), .frameCount(frameCount)
  );

  always #5 pixelClk = ~pixelClk;

  initial begin
    #5ms;
    $display("[TB] FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "[TB] timeout");
  end

  // Box position after n frames: a triangle wave between 0 and range.
  function automatic int tri_pos(int n, int range);
    int p, d;
    p = n % (2 * range / STEP);
    d = p * STEP;
    return (d <= range) ? d : 2 * range - d;
  endfunction

  function automatic int abs_i(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [23:0] expect_pixel(int md, int x, int y, logic de_v, int n);
    int fc, bx, by, gv;
    fc = n % 256;
    if (!de_v) return 24'h000000;
    case (md)
      1: return bar_colors[(x * 8) / W];
      2: return ((((x >> 5) ^ (y >> 5) ^ (fc >> 5)) & 1) == 1) ? 24'hFFFFFF : 24'h000000;
      3: begin
        gv = (x % 256 + fc) % 256;
        return {8'(gv), 8'(gv), 8'(gv)};
      end
      4: begin
        bx = tri_pos(n, W - BOX);
        by = tri_pos(n, H - BOX);
        return (x >= bx && x < bx + BOX && y >= by && y < by + BOX) ? 24'hFFFFFF : 24'h202020;
      end
      5: return 24'hFFFFFF;
      default: begin
        if (abs_i(x - W/2) <= 10 && abs_i(y - H/2) <= 10) return 24'hFFFFFF;
        if (y < BORDER || y >= H - BORDER) return 24'h0000FF;
        if (x < BORDER) return 24'hFF0000;
        if (x >= W - BORDER) return 24'h00FF00;
        return 24'h202020;
      end
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h, expected %h (sofs=%0d, t=%0t)",
               tag, observed, expected, m_sofs, $time);
    end
  endtask

  task automatic model_reset();
    m_sofs    = 0;
    m_mode    = 0;
    m_last_vs = 1'b1;
  endtask

  // One pixel clock: drive inputs, predict with pre-SOF state, then check after the edge.
  task automatic applyStimulus(input logic v, input logic d, input int x, input int y,
                               input logic [2:0] md, input string tag);
    logic [23:0] exp_pix;
    vs      = v;
    de      = d;
    pixelsX = 10'(x);
    pixelsY = 10'(y);
    mode    = md;
    exp_pix = expect_pixel(m_mode, x, y, d, m_sofs);
    if (!m_last_vs && v) begin
      m_mode = int'(md);
      m_sofs++;
    end
    m_last_vs = v;
    @(posedge pixelClk);
    #1;
    checkOutput(tag, {8'h00, r, g, b}, {8'h00, exp_pix});
    checkOutput({tag, "_frame"}, {24'h0, frameCount}, 32'(m_sofs % 256));
  endtask

  task automatic frame_pulse(input logic [2:0] md);
    applyStimulus(1'b0, 1'b0, 0, 0, md, "vs_low");
    applyStimulus(1'b1, 1'b1, $urandom_range(W-1), $urandom_range(H-1), md, "vs_high");
  endtask

  task automatic advance_to(input int n, input logic [2:0] md);
    while (m_sofs < n) frame_pulse(md);
  endtask

  task automatic check_box_corners(input string tag);
    int bx, by;
    bx = tri_pos(m_sofs, W - BOX);
    by = tri_pos(m_sofs, H - BOX);
    applyStimulus(1'b1, 1'b1, bx, by, 3'd4, {tag, "_tl"});
    applyStimulus(1'b1, 1'b1, bx + BOX - 1, by + BOX - 1, 3'd4, {tag, "_br"});
    if (bx > 0) applyStimulus(1'b1, 1'b1, bx - 1, by, 3'd4, {tag, "_left"});
    if (bx + BOX < W) applyStimulus(1'b1, 1'b1, bx + BOX, by, 3'd4, {tag, "_right"});
    if (by > 0) applyStimulus(1'b1, 1'b1, bx, by - 1, 3'd4, {tag, "_above"});
    if (by + BOX < H) applyStimulus(1'b1, 1'b1, bx, by + BOX, 3'd4, {tag, "_below"});
  endtask

  initial begin
    int legacy_pts [7][2] = '{'{10, 300}, '{790, 300}, '{400, 5}, '{10, 5},
                              '{400, 300}, '{410, 310}, '{411, 300}};
    int bar_x [5] = '{50, 100, 699, 700, 799};
    int len;

    model_reset();
    #2;
    checkOutput("reset_rgb", {8'h00, r, g, b}, 32'h0);
    checkOutput("reset_frame", {24'h0, frameCount}, 32'h0);
    @(posedge pixelClk);
    #1;
    nReset = 1'b1;
    model_reset();

    applyStimulus(1'b1, 1'b1, 200, 200, 3'd4, "post_reset");
    foreach (legacy_pts[i])
      applyStimulus(1'b1, 1'b1, legacy_pts[i][0], legacy_pts[i][1], 3'd4, "legacy");
    applyStimulus(1'b1, 1'b0, 10, 300, 3'd4, "legacy_blank");
    applyStimulus(1'b1, 1'b0, 400, 300, 3'd4, "legacy_blank");

    applyStimulus(1'b1, 1'b1, 50, 300, 3'd1, "latch_hold");
    applyStimulus(1'b0, 1'b1, 50, 300, 3'd1, "latch_vs_low");
    applyStimulus(1'b1, 1'b1, 50, 300, 3'd1, "latch_sof_pixel");
    foreach (bar_x[i]) applyStimulus(1'b1, 1'b1, bar_x[i], 300, 3'd4, "bars");

    advance_to(10, 3'd3);
    applyStimulus(1'b1, 1'b1, 250, 100, 3'd4, "ramp_fc10");
    advance_to(31, 3'd2);
    applyStimulus(1'b1, 1'b1, 0, 0, 3'd4, "check_fc31");
    advance_to(32, 3'd2);
    applyStimulus(1'b1, 1'b1, 0, 0, 3'd4, "check_fc32");
    applyStimulus(1'b1, 1'b1, 32, 0, 3'd4, "check_fc32_x32");

    advance_to(290, 3'd4);
    check_box_corners("box_290");
    advance_to(390, 3'd4);
    check_box_corners("box_390");
    applyStimulus(1'b1, 1'b1, 785, 20, 3'd4, "box_390_785_20");
    advance_to(391, 3'd4);
    check_box_corners("box_391");
    advance_to(512, 3'd4);
    check_box_corners("box_512");
    advance_to(780, 3'd4);
    check_box_corners("box_780");
    advance_to(781, 3'd4);
    check_box_corners("box_781");

    applyStimulus(1'b0, 1'b0, 0, 0, 3'd5, "hold_low");
    for (int i = 0; i < 1000; i++)
      applyStimulus(1'b1, 1'($urandom_range(1)), $urandom_range(W-1), $urandom_range(H-1),
                    3'($urandom_range(7)), "vs_held");

    applyStimulus(1'b0, 1'b1, 100, 100, 3'd3, "glitch_pre");
    applyStimulus(1'b1, 1'b1, 100, 100, 3'd3, "glitch");
    applyStimulus(1'b0, 1'b1, 100, 100, 3'd0, "glitch_post");

    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(60, 20);
      for (int c = 0; c < len; c++)
        applyStimulus(1'b0, 1'($urandom_range(3) != 0), $urandom_range(W-1),
                      $urandom_range(H-1), 3'($urandom_range(7)), "random");
      len = $urandom_range(3, 1);
      for (int c = 0; c < len; c++)
        applyStimulus(1'b1, 1'($urandom_range(1)), $urandom_range(W-1),
                      $urandom_range(H-1), 3'($urandom_range(7)), "random_vs");
    end

    advance_to(m_sofs + 1, 3'd5);
    applyStimulus(1'b1, 1'b1, 300, 300, 3'd5, "pre_midreset");
    #2;
    nReset = 1'b0;
    #1;
    checkOutput("midreset_rgb", {8'h00, r, g, b}, 32'h0);
    checkOutput("midreset_frame", {24'h0, frameCount}, 32'h0);
    @(posedge pixelClk);
    #1;
    nReset = 1'b1;
    model_reset();
    applyStimulus(1'b1, 1'b1, 200, 200, 3'd5, "resume_mode0");
    applyStimulus(1'b1, 1'b1, 10, 300, 3'd5, "resume_mode0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
